// File: rtl/ccff_loader.sv
// ccff_loader: streams bitstream words LSB-first into a ccff chain and packs the displaced chain bits into readback words.
module ccff_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int IW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] FULL = CW'(CHAIN_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] in_q, in_d, pk_q, pk_d, m_data_q, m_data_d;
    logic [IW-1:0]     in_cnt_q, in_cnt_d, pk_cnt_q, pk_cnt_d;
    logic              pend_q, pend_d, m_valid_q, m_valid_d, done_q, done_d;
    logic              slot_free, last, accept, flush, word_end;
    logic [WORD_W-1:0] pk_base, pk_new;
    logic [IW-1:0]     pk_base_cnt, pk_new_cnt;

    // Shift qualification: a held completed word that cannot leave blocks the chain.
    always_comb begin
        slot_free = !m_valid_q || m_ready;
        last      = cnt_q == LAST;
        shift_en  = state_q == LOAD && in_cnt_q != '0 && cnt_q < FULL && !(pend_q && !slot_free);
        ccff_head = shift_en & in_q[0];
        s_ready   = state_q == LOAD && (in_cnt_q == '0 || (in_cnt_q == IW'(1) && shift_en && !last));
        accept    = s_valid && s_ready;
        flush     = pend_q && slot_free;
    end

    // Next-state for the input register, readback packer, output slot and FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_d        = in_q;
        in_cnt_d    = in_cnt_q;
        pk_d        = pk_q;
        pk_cnt_d    = pk_cnt_q;
        pend_d      = pend_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q && !m_ready;
        done_d      = 1'b0;
        pk_base     = pend_q ? '0 : pk_q;
        pk_base_cnt = pend_q ? '0 : pk_cnt_q;
        pk_new      = pk_base | (WORD_W'(ccff_tail) << pk_base_cnt);
        pk_new_cnt  = pk_base_cnt + IW'(1);
        word_end    = pk_new_cnt == IW'(WORD_W) || last;
        if (flush) begin
            m_data_d  = pk_q;
            m_valid_d = 1'b1;
            pend_d    = 1'b0;
            pk_d      = '0;
            pk_cnt_d  = '0;
        end
        if (shift_en) begin
            cnt_d    = cnt_q + CW'(1);
            in_d     = in_q >> 1;
            in_cnt_d = in_cnt_q - IW'(1);
            if (word_end && slot_free && !pend_q) begin
                m_data_d  = pk_new;
                m_valid_d = 1'b1;
                pk_d      = '0;
                pk_cnt_d  = '0;
            end else begin
                pk_d     = pk_new;
                pk_cnt_d = pk_new_cnt;
                pend_d   = word_end;
            end
        end
        if (accept) begin
            in_d     = s_data;
            in_cnt_d = IW'(WORD_W);
        end
        if (state_q == IDLE && start) begin
            state_d  = LOAD;
            cnt_d    = '0;
            pk_d     = '0;
            pk_cnt_d = '0;
            pend_d   = 1'b0;
            in_d     = '0;
            in_cnt_d = '0;
        end
        if (state_q == LOAD && shift_en && last) begin
            state_d  = DRAIN;
            in_d     = '0;
            in_cnt_d = '0;
        end
        if (state_q == DRAIN && !pend_q && slot_free) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    // State registers; reset aborts any load in progress.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            in_q      <= '0;
            in_cnt_q  <= '0;
            pk_q      <= '0;
            pk_cnt_q  <= '0;
            pend_q    <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_q      <= in_d;
            in_cnt_q  <= in_cnt_d;
            pk_q      <= pk_d;
            pk_cnt_q  <= pk_cnt_d;
            pend_q    <= pend_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            done_q    <= done_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign busy    = state_q != IDLE;
    assign done    = done_q;
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: directed checks of ccff_loader on 8x8, 8x4 and 10x4 chain/word shapes.
module tb_ccff_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, pre;
    logic [2:0]  start, s_valid, m_ready, s_ready, shift_en, head, m_valid, busy, done, en;
    logic [7:0]  sd_a, md_a, ch_a, ch_b;
    logic [3:0]  sd_b, md_b, sd_c, md_c;
    logic [9:0]  ch_c;
    int          checks = 0, errors = 0;
    int          idx[3], nw[3], nsh[3], nacc[3], nmv[3], ndone[3], dcyc[3], cycn;
    logic [7:0]  wq[3][4], mw[3][4];
    logic [63:0] sev[3], hv[3];

    ccff_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_a (.prog_clk(clk), .pReset(rst_n), .start(start[0]),
        .s_data(sd_a), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .ccff_head(head[0]), .ccff_tail(ch_a[0]),
        .shift_en(shift_en[0]), .m_data(md_a), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .busy(busy[0]), .done(done[0]));
    ccff_loader #(.CHAIN_LEN(8), .WORD_W(4)) u_b (.prog_clk(clk), .pReset(rst_n), .start(start[1]),
        .s_data(sd_b), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .ccff_head(head[1]), .ccff_tail(ch_b[0]),
        .shift_en(shift_en[1]), .m_data(md_b), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .busy(busy[1]), .done(done[1]));
    ccff_loader #(.CHAIN_LEN(10), .WORD_W(4)) u_c (.prog_clk(clk), .pReset(rst_n), .start(start[2]),
        .s_data(sd_c), .s_valid(s_valid[2]), .s_ready(s_ready[2]), .ccff_head(head[2]), .ccff_tail(ch_c[0]),
        .shift_en(shift_en[2]), .m_data(md_c), .m_valid(m_valid[2]), .m_ready(m_ready[2]), .busy(busy[2]), .done(done[2]));

    // Chain models: gated clock passes an edge only when shift_en is high.
    always @(posedge clk) begin
        if (pre) begin
            ch_a <= 8'h3C;
            ch_b <= 8'h3C;
            ch_c <= 10'h33C;
        end else begin
            if (shift_en[0]) ch_a <= {head[0], ch_a[7:1]};
            if (shift_en[1]) ch_b <= {head[1], ch_b[7:1]};
            if (shift_en[2]) ch_c <= {head[2], ch_c[9:1]};
        end
    end

    function automatic logic [7:0] mdv(input int i);
        return i == 0 ? md_a : i == 1 ? {4'h0, md_b} : {4'h0, md_c};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cycn = 0;
        for (int i = 0; i < 3; i++) begin
            idx[i] = 0; nsh[i] = 0; nacc[i] = 0; nmv[i] = 0; ndone[i] = 0; dcyc[i] = -1;
            sev[i] = '0; hv[i] = '0;
            for (int k = 0; k < 4; k++) mw[i][k] = '0;
        end
    endtask

    task automatic words(input int i, input int n, input logic [7:0] w0, w1, w2, w3);
        wq[i][0] = w0; wq[i][1] = w1; wq[i][2] = w2; wq[i][3] = w3;
        nw[i] = n; idx[i] = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) s_valid[i] = en[i] && idx[i] < nw[i];
        sd_a = wq[0][idx[0] % 4];
        sd_b = wq[1][idx[1] % 4][3:0];
        sd_c = wq[2][idx[2] % 4][3:0];
    endtask

    task automatic cyc();
        drive();
        #1;
        for (int i = 0; i < 3; i++) begin
            if (shift_en[i]) begin
                if (nsh[i] < 64) hv[i][nsh[i]] = head[i];
                if (cycn < 64) sev[i][cycn] = 1'b1;
                nsh[i]++;
            end
            if (s_valid[i] && s_ready[i]) begin nacc[i]++; idx[i]++; end
            if (m_valid[i] && m_ready[i]) begin
                if (nmv[i] < 4) mw[i][nmv[i]] = mdv(i);
                nmv[i]++;
            end
            if (done[i]) begin ndone[i]++; dcyc[i] = cycn; end
        end
        cycn++;
        @(negedge clk);
    endtask

    task automatic preload();
        pre = 1'b1;
        @(negedge clk);
        pre = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pre = 1'b0; start = '0; m_ready = '0; en = '0; s_valid = '0;
        for (int i = 0; i < 3; i++) words(i, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        clr();
        @(negedge clk);
        start = '1; en = '1; m_ready = '1;
        drive();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_s_ready", i), s_ready[i], 0);
            chk($sformatf("rst%0d_shift_en", i), shift_en[i], 0);
            chk($sformatf("rst%0d_head", i), head[i], 0);
            chk($sformatf("rst%0d_m_valid", i), m_valid[i], 0);
            chk($sformatf("rst%0d_m_data", i), mdv(i), 0);
            chk($sformatf("rst%0d_busy", i), busy[i], 0);
            chk($sformatf("rst%0d_done", i), done[i], 0);
        end
        start = '0; en = '0;
        preload();
        rst_n = 1'b1;

        clr(); words(0, 2, 8'hA5, 8'hFF, 8'h00, 8'h00);
        en[0] = 1'b1; start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        chk("v1_busy", busy[0], 1);
        repeat (15) cyc();
        en[0] = 1'b0;
        chk("v1_nshift", nsh[0], 8);
        chk("v1_shift_cycles", sev[0], 64'h3FC);
        chk("v1_head_seq", hv[0], 64'hA5);
        chk("v1_words_in", nacc[0], 1);
        chk("v1_words_out", nmv[0], 1);
        chk("v1_readback", mw[0][0], 8'h3C);
        chk("v1_done_count", ndone[0], 1);
        chk("v1_done_cycle", dcyc[0], 11);
        chk("v1_chain", ch_a, 8'hA5);
        chk("v1_idle", busy[0], 0);

        clr(); words(1, 2, 8'h05, 8'h0A, 8'h00, 8'h00);
        start[1] = 1'b1;
        cyc();
        start[1] = 1'b0; en[1] = 1'b1;
        cyc();
        en[1] = 1'b0;
        repeat (6) cyc();
        en[1] = 1'b1;
        repeat (11) cyc();
        en[1] = 1'b0;
        chk("v2_shift_cycles", sev[1], 64'h1E3C);
        chk("v2_head_seq", hv[1], 64'hA5);
        chk("v2_words_in", nacc[1], 2);
        chk("v2_words_out", nmv[1], 2);
        chk("v2_readback0", mw[1][0], 8'h0C);
        chk("v2_readback1", mw[1][1], 8'h03);
        chk("v2_done_count", ndone[1], 1);
        chk("v2_chain", ch_b, 8'hA5);

        clr(); words(2, 4, 8'h0F, 8'h00, 8'h03, 8'h0F);
        en[2] = 1'b1; start[2] = 1'b1;
        cyc();
        start[2] = 1'b0;
        repeat (15) cyc();
        en[2] = 1'b0;
        chk("v3_words_in", nacc[2], 3);
        chk("v3_shift_cycles", sev[2], 64'hFFC);
        chk("v3_head_seq", hv[2], 64'h30F);
        chk("v3_words_out", nmv[2], 3);
        chk("v3_readback0", mw[2][0], 8'h0C);
        chk("v3_readback1", mw[2][1], 8'h03);
        chk("v3_readback2", mw[2][2], 8'h03);
        chk("v3_done_count", ndone[2], 1);
        chk("v3_chain", ch_c, 10'h30F);

        preload();
        clr(); words(2, 3, 8'h0F, 8'h00, 8'h03, 8'h00);
        m_ready[2] = 1'b0; en[2] = 1'b1; start[2] = 1'b1;
        cyc();
        start[2] = 1'b0;
        repeat (14) cyc();
        chk("v4_stall_nshift", nsh[2], 8);
        chk("v4_stall_m_valid", m_valid[2], 1);
        chk("v4_stall_m_data", md_c, 4'hC);
        chk("v4_stall_words_out", nmv[2], 0);
        chk("v4_stall_busy", busy[2], 1);
        m_ready[2] = 1'b1;
        repeat (8) cyc();
        en[2] = 1'b0;
        chk("v4_nshift", nsh[2], 10);
        chk("v4_shift_cycles", sev[2], 64'h183FC);
        chk("v4_words_out", nmv[2], 3);
        chk("v4_readback0", mw[2][0], 8'h0C);
        chk("v4_readback1", mw[2][1], 8'h03);
        chk("v4_readback2", mw[2][2], 8'h03);
        chk("v4_done_count", ndone[2], 1);
        chk("v4_chain", ch_c, 10'h30F);

        preload();
        clr(); words(0, 1, 8'hA5, 8'h00, 8'h00, 8'h00);
        en[0] = 1'b1; start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        repeat (4) cyc();
        chk("v5_pre_nshift", nsh[0], 3);
        rst_n = 1'b0;
        #1;
        chk("v5_busy", busy[0], 0);
        chk("v5_shift_en", shift_en[0], 0);
        chk("v5_s_ready", s_ready[0], 0);
        chk("v5_head", head[0], 0);
        chk("v5_m_valid", m_valid[0], 0);
        chk("v5_m_data", md_a, 0);
        chk("v5_done", done[0], 0);
        @(negedge clk);
        chk("v5_chain_partial", ch_a, 8'hA7);
        rst_n = 1'b1;
        clr(); words(0, 1, 8'hA5, 8'h00, 8'h00, 8'h00);
        start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        repeat (15) cyc();
        en[0] = 1'b0;
        chk("v5_nshift", nsh[0], 8);
        chk("v5_head_seq", hv[0], 64'hA5);
        chk("v5_readback", mw[0][0], 8'hA7);
        chk("v5_done_count", ndone[0], 1);
        chk("v5_chain", ch_a, 8'hA5);

        preload();
        clr(); words(1, 2, 8'h05, 8'h0A, 8'h00, 8'h00);
        en[1] = 1'b1; start[1] = 1'b1;
        cyc();
        start[1] = 1'b0;
        repeat (2) cyc();
        start[1] = 1'b1;
        cyc();
        start[1] = 1'b0;
        repeat (12) cyc();
        en[1] = 1'b0;
        chk("v6_shift_cycles", sev[1], 64'h3FC);
        chk("v6_head_seq", hv[1], 64'hA5);
        chk("v6_words_in", nacc[1], 2);
        chk("v6_words_out", nmv[1], 2);
        chk("v6_readback0", mw[1][0], 8'h0C);
        chk("v6_readback1", mw[1][1], 8'h03);
        chk("v6_done_count", ndone[1], 1);
        chk("v6_done_cycle", dcyc[1], 11);
        chk("v6_chain", ch_b, 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameters: CHAIN_LEN, default 8, number of configuration bits in the ccff chain; WORD_W, default 8, bits per bitstream word.
REQ-002 SHALL have ports: prog_clk  in  1  programming clock; all state on rising edge.
REQ-003 SHALL have ports: pReset  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have ports: start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
REQ-005 SHALL have ports: s_data  in  WORD_W  bitstream word; s_valid  in  1; s_ready  out  1.
REQ-006 SHALL have ports: ccff_head  out  1  serial bit into chain; ccff_tail  in  1  serial bit out of chain end.
REQ-007 SHALL have ports: shift_en  out  1  chain shift enable; the external clock gate passes prog_clk only when 1.
REQ-008 SHALL have ports: m_data  out  WORD_W  readback word; m_valid  out  1; m_ready  in  1.
REQ-009 SHALL have ports: busy  out  1  high outside IDLE; done  out  1  one-cycle pulse on load completion.

Function
REQ-010 SHALL implement FSM IDLE -> LOAD -> DRAIN -> IDLE.
REQ-011 IDLE: start=1 -> LOAD, clear bit counter and readback packer; start while busy SHALL be ignored.
REQ-012 SHALL hold an input shift register of WORD_W bits with a fill flag; s_ready=1 in LOAD when the register is empty or its last bit is being shifted out this cycle.
REQ-013 s_valid & s_ready SHALL load s_data; bit 0 is shifted first, LSB-first.
REQ-014 shift_en SHALL be 1 only when in LOAD, input register holds a bit, bit counter < CHAIN_LEN, and the readback output is not stalled (REQ-018); ccff_head SHALL present the current bit combinationally in that cycle.
REQ-015 The bit counter (width clog2(CHAIN_LEN+1)) SHALL increment on each cycle with shift_en=1; on reaching CHAIN_LEN, FSM SHALL go to DRAIN.
REQ-016 Bits of the last word beyond CHAIN_LEN SHALL be discarded: the input register is cleared on entering DRAIN, and s_ready=0 outside LOAD.
REQ-017 Readback: in every shift_en=1 cycle ccff_tail (the old chain content leaving) SHALL be captured at that edge into a packer, LSB-first.
REQ-018 When the packer holds WORD_W bits or the final (CHAIN_LEN-th) bit is captured, the word SHALL move to m_data with m_valid=1, with unused upper bits zero. If m_valid=1 and m_ready=0 while the packer is full, shift_en SHALL be 0 (stall).
REQ-019 m_valid SHALL stay asserted with m_data stable until m_ready=1.
REQ-020 DRAIN: when m_valid=0 or (m_valid & m_ready), done SHALL pulse for one cycle and the FSM returns to IDLE.
REQ-021 No input underflow: if s_valid=0 with an empty input register, shift_en=0; the chain never shifts undefined data.
REQ-022 CHAIN_LEN not a multiple of WORD_W SHALL produce ceil(CHAIN_LEN/WORD_W) input words consumed and the same number of readback words.

Reset
REQ-023 pReset=0 SHALL asynchronously force IDLE; counter, packer, and input register are cleared; s_ready=0, shift_en=0, ccff_head=0, m_valid=0, m_data=0, busy=0, done=0.
REQ-024 Reset mid-load SHALL abort with no further shift_en; chain contents are left as partially shifted, and the next start restarts from bit 0.

Verification (CHAIN_LEN=8, WORD_W=8 unless stated; chain modelled as 8-bit shift register preloaded 0x3C)
V-1 start, s_data=0xA5 valid, m_ready=1 -> 8 consecutive shift_en cycles, ccff_head sequence 1,0,1,0,0,1,0,1, m_data=0x3C once, done 1 cycle later, chain=0xA5.
V-2 As V-1, s_valid dropped for 3 cycles after the first word is partially consumed (WORD_W=4, 0x5 then 0xA) -> shift_en low exactly during the gap, chain=0xA5, 2 readback words 0xC, 0x3.
V-3 CHAIN_LEN=10, WORD_W=4, words 0xF,0x0,0x3 -> 3 words consumed, upper 2 bits of 0x3 discarded, last readback word zero-padded in bits [3:2].
V-4 m_ready held 0 (WORD_W=4) -> shifting stalls after 8 captured bits with m_data stable; release -> resumes, done follows final word.
V-5 pReset=0 after 3 shifts -> all outputs at reset values immediately; restart loads full 8 bits.
V-6 start asserted during LOAD -> ignored, bit count unaffected.
